acc_veri_rd_sched: RTL and testbench

//  Sequences verification-result readback into the verification TX path.
//  On start, walks a window of the 128-bit result buffer. Each veri_ins_push

---
 rtl/acc_veri_rd_sched.sv | 131 +++++++++++++
 tb/tb_acc_veri_rd_sched.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/acc_veri_rd_sched.sv
// Credit-paced readback of the 128-bit verification result buffer into the TX packer.
// Each veri_ins_push credit buys one buffer read; returned words leave as one-cycle vld pulses.
module acc_veri_rd_sched #(
    parameter int ADDR_W  = 10,
    parameter int RD_LAT  = 2,
    parameter int MIN_GAP = 5
) (
    input  logic              clk_200M,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_num,
    input  logic              abort,
    input  logic              veri_ins_push,
    output logic              buf_rd_en,
    output logic [ADDR_W-1:0] buf_rd_addr,
    input  logic [127:0]      buf_rd_data,
    output logic [127:0]      veri_data_out,
    output logic              veri_data_out_vld,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_left,
    output logic              credit_ovf
);

    localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(MIN_GAP - 1);
    localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);
    localparam logic [2:0]        LAT_LAST = 3'(RD_LAT - 1);
    localparam logic [ADDR_W:0]   WL_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READ,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        lat_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              credit;
    logic              start_ok;
    logic              abort_hit;
    logic              enter_read;
    logic              send_ok;

    assign start_ok   = (state == ST_IDLE) && start && !abort;
    assign abort_hit  = (state != ST_IDLE) && abort;
    assign enter_read = (state == ST_WAIT) && (state_nxt == ST_READ);
    assign send_ok    = (state == ST_SEND) && !abort;

    assign buf_rd_en   = (state == ST_READ) && (lat_cnt == '0);
    assign buf_rd_addr = addr;
    assign busy        = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_ok) state_nxt = (word_num == '0) ? ST_DONE : ST_WAIT;
            ST_WAIT: if (credit && (gap_cnt == '0)) state_nxt = ST_READ;
            ST_READ: if (lat_cnt == LAT_LAST) state_nxt = ST_SEND;
            ST_SEND: state_nxt = (words_left == WL_ONE) ? ST_DONE : ST_WAIT;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (abort_hit) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk_200M or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            lat_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= ((state == ST_READ) && (state_nxt == ST_READ)) ? lat_cnt + 3'd1 : '0;
            if (send_ok)
                gap_cnt <= GAP_LOAD;
            else if (gap_cnt != '0)
                gap_cnt <= gap_cnt - GAP_ONE;
        end
    end

    // A push coinciding with READ entry replaces the credit being consumed.
    always_ff @(posedge clk_200M or negedge rst_n) begin
        if (!rst_n) begin
            credit     <= 1'b0;
            credit_ovf <= 1'b0;
        end else begin
            if (veri_ins_push)
                credit <= 1'b1;
            else if (enter_read)
                credit <= 1'b0;
            if (veri_ins_push && credit)
                credit_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk_200M or negedge rst_n) begin
        if (!rst_n) begin
            addr       <= '0;
            words_left <= '0;
        end else if (start_ok) begin
            addr       <= base_addr;
            words_left <= word_num;
        end else if (abort_hit) begin
            words_left <= '0;
        end else if (send_ok) begin
            addr       <= addr + ADDR_ONE;
            words_left <= words_left - WL_ONE;
        end
    end

    always_ff @(posedge clk_200M or negedge rst_n) begin
        if (!rst_n) begin
            veri_data_out     <= '0;
            veri_data_out_vld <= 1'b0;
            done              <= 1'b0;
        end else begin
            veri_data_out_vld <= send_ok;
            done              <= (state == ST_DONE) && !abort;
            if (send_ok)
                veri_data_out <= buf_rd_data;
        end
    end

endmodule

// File: tb/tb_acc_veri_rd_sched.sv
// Directed bench for acc_veri_rd_sched: behavioural 2-cycle buffer, event logs, hand-computed expectations.
module tb_acc_veri_rd_sched;

    logic         clk_200M = 1'b0;
    logic         rst_n;
    logic         start;
    logic [9:0]   base_addr;
    logic [10:0]  word_num;
    logic         abort;
    logic         veri_ins_push;
    logic         buf_rd_en;
    logic [9:0]   buf_rd_addr;
    logic [127:0] buf_rd_data;
    logic [127:0] veri_data_out;
    logic         veri_data_out_vld;
    logic         busy;
    logic         done;
    logic [10:0]  words_left;
    logic         credit_ovf;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [127:0] pipe0, pipe1;
    logic [9:0]   rd_a [64];
    int           rd_c [64];
    logic [127:0] vd   [64];
    int           vc   [64];
    int           dc   [64];
    int           n_rd = 0, n_vld = 0, n_done = 0;

    acc_veri_rd_sched #(.ADDR_W(10), .RD_LAT(2), .MIN_GAP(5)) dut (
        .clk_200M          (clk_200M),
        .rst_n             (rst_n),
        .start             (start),
        .base_addr         (base_addr),
        .word_num          (word_num),
        .abort             (abort),
        .veri_ins_push     (veri_ins_push),
        .buf_rd_en         (buf_rd_en),
        .buf_rd_addr       (buf_rd_addr),
        .buf_rd_data       (buf_rd_data),
        .veri_data_out     (veri_data_out),
        .veri_data_out_vld (veri_data_out_vld),
        .busy              (busy),
        .done              (done),
        .words_left        (words_left),
        .credit_ovf        (credit_ovf)
    );

    always #5 clk_200M = ~clk_200M;

    function automatic logic [127:0] fdat(input logic [9:0] a);
        return {4{22'h15A5A5, a}};
    endfunction

    // Buffer model: data valid two cycles after the strobe, junk otherwise.
    always @(posedge clk_200M) begin
        pipe0 <= buf_rd_en ? fdat(buf_rd_addr) : {4{32'hDEADBEEF}};
        pipe1 <= pipe0;
        cyc   <= cyc + 1;
    end
    assign buf_rd_data = pipe1;

    always @(negedge clk_200M) begin
        if (buf_rd_en && n_rd < 64) begin
            rd_a[n_rd] = buf_rd_addr;
            rd_c[n_rd] = cyc;
            n_rd++;
        end
        if (veri_data_out_vld && n_vld < 64) begin
            vd[n_vld] = veri_data_out;
            vc[n_vld] = cyc;
            n_vld++;
        end
        if (done && n_done < 64) begin
            dc[n_done] = cyc;
            n_done++;
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_200M);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse_start(input logic [9:0] b, input logic [10:0] n);
        base_addr = b;
        word_num  = n;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic pulse_push();
        veri_ins_push = 1'b1;
        tick();
        veri_ins_push = 1'b0;
    endtask

    initial begin
        int r0, v0, d0, s, k;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; veri_ins_push = 1'b0;
        base_addr = '0; word_num = '0;
        idle(3);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_vld",  128'(veri_data_out_vld), 128'd0);
        check("rst_rden", 128'(buf_rd_en), 128'd0);
        check("rst_wl",   128'(words_left), 128'd0);
        check("rst_ovf",  128'(credit_ovf), 128'd0);
        check("rst_data", veri_data_out, 128'd0);
        rst_n = 1'b1;
        tick();

        // three words from 0, one push per 20 cycles, stray start ignored mid-run
        r0 = n_rd; v0 = n_vld; d0 = n_done;
        pulse_start(10'd0, 11'd3);
        check("t1_busy", 128'(busy), 128'd1);
        check("t1_wl", 128'(words_left), 128'd3);
        pulse_push(); idle(19);
        pulse_push(); pulse_start(10'd500, 11'd7); idle(18);
        pulse_push(); idle(19);
        check("t1_nrd", 128'(n_rd - r0), 128'd3);
        check("t1_nvld", 128'(n_vld - v0), 128'd3);
        for (int i = 0; i < 3; i++) begin
            check("t1_addr", 128'(rd_a[r0+i]), 128'(i));
            check("t1_data", vd[v0+i], fdat(10'(i)));
            check("t1_lat", 128'(vc[v0+i] - rd_c[r0+i]), 128'd3);
        end
        check("t1_ndone", 128'(n_done - d0), 128'd1);
        check("t1_done_cyc", 128'(dc[d0] - vc[v0+2]), 128'd1);
        check("t1_busy_end", 128'(busy), 128'd0);
        check("t1_wl_end", 128'(words_left), 128'd0);
        check("t1_ovf", 128'(credit_ovf), 128'd0);

        // credit pushed while idle is consumed by the next start
        r0 = n_rd; v0 = n_vld; d0 = n_done;
        pulse_push(); idle(2);
        s = cyc;
        pulse_start(10'd5, 11'd1); idle(12);
        check("t2_nrd", 128'(n_rd - r0), 128'd1);
        check("t2_rd_cyc", 128'(rd_c[r0] - s), 128'd2);
        check("t2_addr", 128'(rd_a[r0]), 128'd5);
        check("t2_lat", 128'(vc[v0] - rd_c[r0]), 128'd3);
        check("t2_data", vd[v0], fdat(10'd5));
        check("t2_ndone", 128'(n_done - d0), 128'd1);

        // address wrap
        r0 = n_rd; v0 = n_vld;
        pulse_start(10'd1023, 11'd2);
        pulse_push(); idle(19); pulse_push(); idle(19);
        check("t3_nrd", 128'(n_rd - r0), 128'd2);
        check("t3_addr0", 128'(rd_a[r0]), 128'd1023);
        check("t3_addr1", 128'(rd_a[r0+1]), 128'd0);
        check("t3_data1", vd[v0+1], fdat(10'd0));

        // double push during the gap: overflow flagged, one read only
        r0 = n_rd; d0 = n_done;
        pulse_start(10'd10, 11'd2);
        pulse_push();
        k = 0;
        while (!veri_data_out_vld && k < 40) begin tick(); k++; end
        check("t4_vld_seen", 128'(veri_data_out_vld), 128'd1);
        pulse_push(); tick(); pulse_push(); idle(30);
        check("t4_nrd", 128'(n_rd - r0), 128'd2);
        check("t4_addr1", 128'(rd_a[r0+1]), 128'd11);
        check("t4_ovf", 128'(credit_ovf), 128'd1);
        check("t4_ndone", 128'(n_done - d0), 128'd1);

        rst_n = 1'b0;
        #1;
        check("rst2_ovf", 128'(credit_ovf), 128'd0);
        check("rst2_busy", 128'(busy), 128'd0);
        tick(); rst_n = 1'b1; tick();

        // zero-length request
        r0 = n_rd; v0 = n_vld; d0 = n_done;
        s = cyc;
        pulse_start(10'd7, 11'd0); idle(6);
        check("t5_ndone", 128'(n_done - d0), 128'd1);
        check("t5_done_cyc", 128'(dc[d0] - s), 128'd2);
        check("t5_nrd", 128'(n_rd - r0), 128'd0);
        check("t5_nvld", 128'(n_vld - v0), 128'd0);
        check("t5_busy", 128'(busy), 128'd0);

        // abort on the read strobe, then a clean restart
        v0 = n_vld; d0 = n_done;
        pulse_push();
        pulse_start(10'd20, 11'd4);
        k = 0;
        while (!buf_rd_en && k < 40) begin tick(); k++; end
        check("t6_rd_seen", 128'(buf_rd_en), 128'd1);
        abort = 1'b1; tick(); abort = 1'b0;
        check("t6_busy", 128'(busy), 128'd0);
        check("t6_wl", 128'(words_left), 128'd0);
        idle(10);
        check("t6_nvld", 128'(n_vld - v0), 128'd0);
        check("t6_ndone", 128'(n_done - d0), 128'd0);
        check("t6_data", veri_data_out, 128'd0);
        r0 = n_rd;
        pulse_push();
        pulse_start(10'd30, 11'd1); idle(12);
        check("t6_re_nrd", 128'(n_rd - r0), 128'd1);
        check("t6_re_addr", 128'(rd_a[r0]), 128'd30);
        check("t6_re_data", vd[v0], fdat(10'd30));
        check("t6_re_ndone", 128'(n_done - d0), 128'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
